axi_stream_slave: RTL
=====================

// Module: axi_stream_slave
// PURPOSE
//   AXI-Stream sink and checker for the header-insert bench; the receiving end of the stream
//   source. Drives ready with a periodic backpressure pattern and checks each accepted beat
//   against an incrementing sequence and all-ones keep. On each packet's last beat it reports
//   the beat count, per-packet error status and a packet counter.
// PARAMETERS
//   DATA_WIDTH      32              data bus width (bits)
//   DATA_BYTE_WIDTH DATA_WIDTH/8    keep width
//   STALL_PERIOD    16              cycles ready may be high per backpressure period (>=1)
//   STALL_DURATION  3               cycles ready forced low per period; 0 = no backpressure
//   EXPECT_START    0               expected data value of first beat of every packet
//   CNT_WIDTH       16              width of beat and packet counters
// PORTS
//   clk         in   1                clock, rising edge
//   rst         in   1                asynchronous reset, active-high
//   valid       in   1                beat valid from source
//   data        in   DATA_WIDTH       beat data
//   keep        in   DATA_BYTE_WIDTH  byte qualifiers
//   last        in   1                final beat of packet
//   ready       out  1                sink ready, registered
//   pkt_done    out  1                1-cycle pulse: packet report valid
//   pkt_beats   out  CNT_WIDTH        accepted beats in reported packet, last included
//   pkt_error   out  1                reported packet had >=1 seq/keep/stability error
//   pkt_count   out  CNT_WIDTH        packets completed since reset, wraps
//   err_sticky  out  1                any error since reset
// BEHAVIOUR
//   - Reset (async): ready=0, pkt_done=0, pkt_beats=0, pkt_error=0, pkt_count=0,
//     err_sticky=0, state=RECV, stall counter sc=0, expect=EXPECT_START, beat cnt=0.
//   - Beat accepted iff valid && ready at a rising edge. No combinational input-to-output path.
//   - sc free-runs 0..STALL_PERIOD+STALL_DURATION-1, wraps to 0; independent of FSM/traffic.
//   - ready flop: ready <= (next_state==RECV) && (sc_next < STALL_PERIOD). First edge after
//     rst release drives ready=1 (sc=0).
//   - FSM: RECV -> DONE on accepted beat with last=1; DONE -> RECV unconditionally (1 cycle).
//     ready=0 throughout DONE, even if sc lies in the ready window.
//   - Per accepted beat in RECV: beat cnt +1 (saturates at all-ones); expect <= data+1 (wraps
//     at 2^DATA_WIDTH); seq error if data!=expect; keep error if keep!=all-ones.
//   - Stability error: previous cycle valid&&!ready and current valid=1, but data or last
//     changed. Valid dropping without handshake is legal, not an error.
//   - Errors OR into a per-packet flag; err_sticky sets on any error, clears only on reset.
//   - Last accepted (edge t): at t, pkt_beats<=cnt+1, pkt_error<=flag|this-beat error,
//     pkt_count+1, pkt_done<=1; cnt, flag cleared, expect<=EXPECT_START. At t+1 pkt_done<=0.
//   - pkt_beats/pkt_error hold until next report. Single-beat packet reports pkt_beats=1.
//   - Errors on last beat count toward the packet being reported, not the next one.
//   - Reset mid-packet: partial packet discarded, no report; next packet starts at EXPECT_START.
// TESTING
//   1 STALL_DURATION=0, continuous valid, data 0..99, last on 99 -> ready never low except
//     DONE cycle; one pkt_done; pkt_beats=100, pkt_error=0, pkt_count=1.
//   2 Defaults (16/3), same packet -> ready low 3 cycles every 19; held beats accepted once;
//     pkt_beats=100, pkt_error=0, err_sticky=0.
//   3 Source skips value 50 -> pkt_beats=99, pkt_error=1, err_sticky=1; next clean packet
//     reports pkt_error=0, err_sticky stays 1.
//   4 One beat with keep=4'b0111 -> pkt_error=1; data changed while stalled -> pkt_error=1.
//   5 Two back-to-back packets 0..99 -> ready=0 in each DONE cycle; pkt_count=2, both clean.
//   6 rst pulsed after 40 beats, then packet 0..99 -> no report for partial; then
//     pkt_beats=100, pkt_error=0, pkt_count=1.

Source files
------------

// File: rtl/axi_stream_slave.sv
// axi_stream_slave: AXI-Stream sink/checker.
// Applies a periodic backpressure pattern on ready, checks every accepted beat
// against an incrementing sequence with all-ones keep, watches that a stalled
// beat is held stable, and reports beat count / error status per packet.
module axi_stream_slave #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int                    STALL_PERIOD    = 16,
  parameter int                    STALL_DURATION  = 3,
  parameter logic [DATA_WIDTH-1:0] EXPECT_START    = '0,
  parameter int                    CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [DATA_WIDTH-1:0]      data,
  input  logic [DATA_BYTE_WIDTH-1:0] keep,
  input  logic                       last,
  output logic                       ready,
  output logic                       pkt_done,
  output logic [CNT_WIDTH-1:0]       pkt_beats,
  output logic                       pkt_error,
  output logic [CNT_WIDTH-1:0]       pkt_count,
  output logic                       err_sticky
);

  // Stall counter spans one full ready-high + ready-low period.
  localparam int SC_MAX = STALL_PERIOD + STALL_DURATION - 1;
  localparam int SC_W   = (SC_MAX < 1) ? 1 : $clog2(SC_MAX + 1);

  typedef enum logic [0:0] {
    S_RECV = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [SC_W-1:0]         r_sc;
  logic [SC_W-1:0]         w_sc_next;
  logic                    r_ready;
  logic                    w_ready_next;

  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [CNT_WIDTH-1:0]    w_cnt_inc;
  logic [DATA_WIDTH-1:0]   r_expect;
  logic                    r_flag;

  // Previous-cycle view of the bus, used to detect a stalled beat changing.
  logic                    r_prev_stall;
  logic [DATA_WIDTH-1:0]   r_prev_data;
  logic                    r_prev_last;

  logic                    r_pkt_done;
  logic [CNT_WIDTH-1:0]    r_pkt_beats;
  logic                    r_pkt_error;
  logic [CNT_WIDTH-1:0]    r_pkt_count;
  logic                    r_err_sticky;

  logic                    w_accept;
  logic                    w_last_acc;
  logic                    w_seq_err;
  logic                    w_keep_err;
  logic                    w_stab_err;
  logic                    w_err;

  // ready is registered and only ever high in RECV, so it alone qualifies a handshake.
  assign w_accept   = valid && r_ready;
  assign w_last_acc = w_accept && last;
  assign w_seq_err  = w_accept && (data != r_expect);
  assign w_keep_err = w_accept && (keep != {DATA_BYTE_WIDTH{1'b1}});
  // Dropping valid while stalled is legal; only a changed beat under valid is flagged.
  assign w_stab_err = r_prev_stall && valid &&
                      ((data != r_prev_data) || (last != r_prev_last));
  assign w_err      = w_seq_err || w_keep_err || w_stab_err;
  assign w_cnt_inc  = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_sc_next  = (r_sc == SC_W'(SC_MAX)) ? '0 : r_sc + 1'b1;

  // State register: FSM state, free-running stall counter and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RECV;
      r_sc    <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sc    <= w_sc_next;
      r_ready <= w_ready_next;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle after the last beat.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RECV:  if (w_last_acc) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_RECV;
      default: w_state_next = S_RECV;
    endcase
  end

  // Output logic: ready opens only in RECV and inside the high part of the stall period.
  always_comb begin
    w_ready_next = (w_state_next == S_RECV) && (int'(w_sc_next) < STALL_PERIOD);
  end

  // Per-packet checking datapath and packet report registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_expect     <= EXPECT_START;
      r_flag       <= 1'b0;
      r_prev_stall <= 1'b0;
      r_prev_data  <= '0;
      r_prev_last  <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_beats  <= '0;
      r_pkt_error  <= 1'b0;
      r_pkt_count  <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_prev_stall <= valid && !r_ready;
      r_prev_data  <= data;
      r_prev_last  <= last;
      r_pkt_done   <= w_last_acc;
      if (w_err) r_err_sticky <= 1'b1;

      if (w_last_acc) begin
        // Errors on the last beat belong to the packet being reported.
        r_pkt_beats <= w_cnt_inc;
        r_pkt_error <= r_flag || w_err;
        r_pkt_count <= r_pkt_count + 1'b1;
        r_cnt       <= '0;
        r_flag      <= 1'b0;
        r_expect    <= EXPECT_START;
      end else begin
        if (w_err) r_flag <= 1'b1;
        if (w_accept) begin
          r_cnt    <= w_cnt_inc;
          r_expect <= data + 1'b1;
        end
      end
    end
  end

  assign ready      = r_ready;
  assign pkt_done   = r_pkt_done;
  assign pkt_beats  = r_pkt_beats;
  assign pkt_error  = r_pkt_error;
  assign pkt_count  = r_pkt_count;
  assign err_sticky = r_err_sticky;

endmodule
